// File: rtl/socetlib_fifo_pkg.sv
// Shared FIFO types: status flag bundle and read-mode selectors.
package socetlib_fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overrun;
    logic underrun;
  } fifo_status_t;

endpackage

// File: rtl/socetlib_wrap_ctr.sv
// Modulo-(MAX+1) counter used for the FIFO read and write pointers.
module socetlib_wrap_ctr #(
  parameter int unsigned MAX = 5
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         inc,
  input  logic                         clear,
  output logic [$clog2(MAX+1)-1:0]     value
);

  localparam int unsigned W = $clog2(MAX + 1);

  // Advance on inc, wrapping MAX -> 0; clear has priority over inc.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == W'(MAX)) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/socetlib_fifo_v2.sv
// Circular-buffer FIFO, arbitrary depth, FWFT or registered read.
module socetlib_fifo_v2
  import socetlib_fifo_pkg::*;
#(
  parameter type T        = logic [7:0],
  parameter int  DEPTH    = 6,
  parameter int  AF_LEVEL = DEPTH - 1,
  parameter int  AE_LEVEL = 1,
  parameter int  FWFT     = FIFO_MODE_FWFT
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         clear,
  input  logic                         WEN,
  input  T                             wdata,
  input  logic                         REN,
  output T                             rdata,
  output logic                         rvalid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overrun,
  output logic                         underrun
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  // Reject illegal configurations at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $error("socetlib_fifo_v2: DEPTH must be >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("socetlib_fifo_v2: AF_LEVEL must be <= DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("socetlib_fifo_v2: AE_LEVEL must be < DEPTH");
  end
  if (FWFT != FIFO_MODE_FWFT && FWFT != FIFO_MODE_REG) begin : g_bad_mode
    $error("socetlib_fifo_v2: FWFT must be 0 or 1");
  end

  T                mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            racc;
  logic            wacc;
  logic            wr_en;
  logic            rd_en;
  logic [CW-1:0]   count_next;
  fifo_status_t    status;

  // Accepts; clear suppresses any accept in its cycle.
  assign racc  = REN && !empty;
  assign wacc  = WEN && (!full || racc);
  assign wr_en = wacc && !clear;
  assign rd_en = racc && !clear;

  // Flag decode from the registered count.
  assign status.full         = (count == FULL_CNT);
  assign status.empty        = (count == '0);
  assign status.almost_full  = (count >= AF_CNT);
  assign status.almost_empty = (count <= AE_CNT);
  assign status.overrun      = overrun;
  assign status.underrun     = underrun;

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  socetlib_wrap_ctr #(.MAX(DEPTH - 1)) u_wptr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (wr_en),
    .clear (clear),
    .value (wptr)
  );

  socetlib_wrap_ctr #(.MAX(DEPTH - 1)) u_rptr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (rd_en),
    .clear (clear),
    .value (rptr)
  );

  // Next occupancy; simultaneous accepts cancel so count never passes DEPTH.
  always_comb begin
    count_next = count;
    case ({wacc, racc})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Occupancy and sticky error flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      count <= count_next;
      if (WEN && !wacc) overrun  <= 1'b1;
      if (REN && !racc) underrun <= 1'b1;
    end
  end

  // Storage write at the write pointer; contents need no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head entry is presented directly whenever the FIFO holds data.
    assign rdata  = empty ? T'('0) : mem[rptr];
    assign rvalid = !empty;
  end else begin : g_reg
    T     rdata_q;
    logic rvalid_q;

    // Capture the head on each pop; rvalid pulses for one cycle.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        rdata_q  <= T'('0);
        rvalid_q <= 1'b0;
      end else if (clear) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= racc;
        if (racc) rdata_q <= mem[rptr];
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_socetlib_fifo_v2.sv
// Directed bench: one FWFT instance and one registered-read instance on shared inputs.
module tb_socetlib_fifo_v2;

  logic       CLK;
  logic       nRST;
  logic       clear;
  logic       WEN;
  logic [7:0] wdata;
  logic       REN;

  logic [7:0] rdata_f, rdata_r;
  logic       rvalid_f, rvalid_r;
  logic       full_f, full_r, empty_f, empty_r;
  logic       af_f, af_r, ae_f, ae_r;
  logic [2:0] count_f, count_r;
  logic       ovr_f, ovr_r, und_f, und_r;

  int total = 0;
  int bad   = 0;

  socetlib_fifo_v2 #(.T(logic [7:0]), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) dut_f (
    .CLK(CLK), .nRST(nRST), .clear(clear), .WEN(WEN), .wdata(wdata), .REN(REN),
    .rdata(rdata_f), .rvalid(rvalid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overrun(ovr_f), .underrun(und_f)
  );

  socetlib_fifo_v2 #(.T(logic [7:0]), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) dut_r (
    .CLK(CLK), .nRST(nRST), .clear(clear), .WEN(WEN), .wdata(wdata), .REN(REN),
    .rdata(rdata_r), .rvalid(rvalid_r), .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r), .count(count_r),
    .overrun(ovr_r), .underrun(und_r)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    WEN = w; wdata = d; REN = r; clear = c;
    @(posedge CLK);
    #1;
    WEN = 1'b0; REN = 1'b0; clear = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; clear = 1'b0; WEN = 1'b0; REN = 1'b0; wdata = 8'h00;
    #2;
    check("rst_count",  32'(count_f), 32'd0);
    check("rst_empty",  32'(empty_f), 32'd1);
    check("rst_rdata_f", 32'(rdata_f), 32'd0);
    check("rst_rvalid_r", 32'(rvalid_r), 32'd0);
    check("rst_rdata_r", 32'(rdata_r), 32'd0);
    check("rst_ovr",    32'(ovr_f), 32'd0);
    @(posedge CLK); #2;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Fill and drain
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check("fill_count", 32'(count_f), 32'(i + 1));
      check("fill_af", 32'(af_f), ((i + 1) >= 4) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(ae_f), ((i + 1) <= 1) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(full_f), 32'd1);
    check("fill_ovr0", 32'(ovr_f), 32'd0);
    step(1'b1, 8'h15, 1'b0, 1'b0);
    check("ovr_set", 32'(ovr_f), 32'd1);
    check("ovr_count", 32'(count_f), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("drain_data", 32'(rdata_f), 32'(8'h10 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty_f), 32'd1);
    check("drain_und0", 32'(und_f), 32'd0);
    check("drain_ovr_sticky", 32'(ovr_f), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovr", 32'(ovr_f), 32'd0);

    // Wrap: 13 write/read pairs walk both pointers around several times
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("wrap_count1", 32'(count_f), 32'd1);
      check("wrap_data", 32'(rdata_f), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_count0", 32'(count_f), 32'd0);
    end

    // Simultaneous read/write while full
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    check("sim_full", 32'(full_f), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("sim_head", 32'(rdata_f), 32'(8'h20 + i));
      step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
      check("sim_count", 32'(count_f), 32'd5);
      check("sim_ovr", 32'(ovr_f), 32'd0);
    end
    begin
      logic [7:0] exp_q [5];
      exp_q[0] = 8'h23; exp_q[1] = 8'h24; exp_q[2] = 8'hA0; exp_q[3] = 8'hA1; exp_q[4] = 8'hA2;
      for (int i = 0; i < 5; i++) begin
        check("sim_drain", 32'(rdata_f), 32'(exp_q[i]));
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    check("sim_empty", 32'(empty_f), 32'd1);

    // Simultaneous read/write while empty: write wins, read rejected
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("emp_count", 32'(count_f), 32'd1);
    check("emp_und", 32'(und_f), 32'd1);
    check("emp_rdata", 32'(rdata_f), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("emp_clr_und", 32'(und_f), 32'd0);

    // Registered read mode
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("reg_rvalid_idle", 32'(rvalid_r), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("reg_rvalid1", 32'(rvalid_r), 32'd1);
    check("reg_rdata1", 32'(rdata_r), 32'h33);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("reg_rvalid0", 32'(rvalid_r), 32'd0);
    check("reg_rdata_hold", 32'(rdata_r), 32'h33);

    // Clear overrides a concurrent write
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_pre_count", 32'(count_f), 32'd3);
    check("clr_pre_ovr", 32'(ovr_f), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_count", 32'(count_f), 32'd0);
    check("clr_ovr", 32'(ovr_f), 32'd0);
    check("clr_empty", 32'(empty_f), 32'd1);
    check("clr_rvalid_r", 32'(rvalid_r), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_no_write", 32'(count_f), 32'd0);

    // Asynchronous reset in the middle of a write
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    check("ar_pre_count", 32'(count_f), 32'd1);
    check("ar_pre_rdata_r", 32'(rdata_r), 32'h61);
    WEN = 1'b1; wdata = 8'h63;
    #2;
    nRST = 1'b0;
    #1;
    check("ar_count", 32'(count_f), 32'd0);
    check("ar_empty", 32'(empty_f), 32'd1);
    check("ar_rdata_f", 32'(rdata_f), 32'd0);
    check("ar_rdata_r", 32'(rdata_r), 32'd0);
    check("ar_rvalid_r", 32'(rvalid_r), 32'd0);
    @(posedge CLK); #1;
    check("ar_hold_count", 32'(count_f), 32'd0);
    #2;
    nRST = 1'b1;
    WEN = 1'b0;
    @(posedge CLK); #1;
    check("ar_post_empty", 32'(empty_f), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/socetlib_fifo_v2.md
SOCETLIB_FIFO_V2 -- requirements
Module: socetlib_fifo_v2

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- T, logic [7:0], entry type.
- DEPTH, 6, number of entries; any integer >= 2, not restricted to powers of 2.
- AF_LEVEL, DEPTH-1, almost_full threshold.
- AE_LEVEL, 1, almost_empty threshold.
- FWFT, 1, read mode: 1 = first-word-fall-through, 0 = registered read.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, clock.
- nRST, in, 1, reset, asynchronous, active-low.
- clear, in, 1, synchronous flush.
- WEN, in, 1, write request.
- wdata, in, T, write data.
- REN, in, 1, read request.
- rdata, out, T, read data.
- rvalid, out, 1, rdata holds a popped or head entry.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AF_LEVEL.
- almost_empty, out, 1, count <= AE_LEVEL.
- count, out, $clog2(DEPTH+1), occupancy.
- overrun, out, 1, sticky write-rejected flag.
- underrun, out, 1, sticky read-rejected flag.
REQ-003 Elaboration SHALL fail with $error if DEPTH < 2, AF_LEVEL > DEPTH, AE_LEVEL >= DEPTH, or FWFT is not 0 or 1.

Function
REQ-004 Read accept racc SHALL equal REN && !empty.
REQ-005 Write accept wacc SHALL equal WEN && (!full || racc): a simultaneous read and write on a full FIFO succeeds, and count is unchanged.
REQ-006 On an empty FIFO with WEN and REN both high, the write SHALL be accepted and the read rejected; there is no bypass path.
REQ-007 Read and write pointers SHALL advance by 1 on each accept and wrap from DEPTH-1 to 0.
REQ-008 Next count SHALL equal count + wacc - racc, with no intermediate overflow at count == DEPTH.
REQ-009 full, empty, almost_full, almost_empty SHALL be combinational decodes of the registered count.
REQ-010 overrun SHALL set on WEN && !wacc; underrun SHALL set on REN && !racc; both SHALL hold until clear or reset.
REQ-011 With FWFT=1:
- rdata SHALL equal the head entry when !empty, else '0.
- rvalid SHALL equal !empty.
- racc pops in the same cycle.
REQ-012 With FWFT=0:
- On racc, rdata SHALL register the head entry and rvalid SHALL be 1 for exactly the next cycle.
- rdata SHALL hold its value until the next racc.
REQ-013 clear SHALL override WEN and REN in the same cycle: pointers, count, overrun, underrun and rvalid go to 0; storage is untouched; no accept occurs.
REQ-014 Storage writes SHALL occur only on wacc, at the write pointer.

Reset
REQ-015 While nRST is low, pointers, count, overrun, underrun and rvalid SHALL be 0, and rdata SHALL be '0, in both modes.
REQ-016 Storage contents SHALL NOT require reset.
REQ-017 Deassertion of nRST mid-traffic SHALL leave the block empty, with all accepts in the reset cycle discarded.

Structure
REQ-018 A shared package socetlib_fifo_pkg SHALL hold the fifo_status_t struct (full, empty, almost_full, almost_empty, overrun, underrun) and the FIFO_MODE_FWFT / FIFO_MODE_REG constants.
REQ-019 Pointer wrap logic SHALL be one reusable sub-module, socetlib_wrap_ctr (parameter MAX; inputs inc, clear; output value), instantiated for each pointer.

Verification (DEPTH=5, AF_LEVEL=4, AE_LEVEL=1, T=8-bit)
REQ-020 Fill/drain (FWFT=1): write 0x10..0x14.
- Expect full=1, count=5, almost_full asserted at count 4.
- A 6th write sets overrun=1 and count stays 5.
- Reads return 0x10..0x14 in order, then empty=1.
REQ-021 Wrap: perform 13 writes, each followed by a read, with data 0..12.
- Data returns in order.
- Pointers wrap at 4 -> 0.
- count never exceeds 1.
REQ-022 Full simultaneous: fill to 5, then WEN+REN for 3 cycles with data 0xA0..0xA2.
- count stays 5 and overrun stays 0.
- Final drain order is entries 4..5 of the original fill, then 0xA0..0xA2.
REQ-023 Empty simultaneous: WEN+REN on empty with data 0x55.
- Next cycle: count=1, underrun=1, rdata=0x55 (FWFT=1).
REQ-024 Registered mode (FWFT=0): write 0x33 then REN.
- Next cycle: rvalid=1, rdata=0x33.
- Cycle after: rvalid=0, rdata still 0x33.
REQ-025 Clear/reset: with count=3 and overrun=1, assert clear together with WEN.
- Next cycle: count=0, overrun=0, empty=1.
- Async nRST low mid-write: all outputs go to reset values immediately.
